// File: rtl/can_defs_pkg.sv
// Shared CAN definitions: frame-state encoding, field widths and captured-field struct.
package can_defs;

  localparam int CAN_ID_BITS        = 11;
  localparam int CAN_DLC_BITS       = 4;
  localparam int CAN_CRC_BITS       = 15;
  localparam int CAN_EOF_BITS       = 7;
  localparam int CAN_STUFF_LEN      = 5;
  localparam int CAN_RECOVERY_BITS  = 11;
  localparam int CAN_MAX_DATA_BYTES = 8;
  localparam int CAN_FRAME_BYTES    = 10;

  typedef enum logic [3:0] {
    STATE_IDLE      = 4'd0,
    STATE_ID_STD    = 4'd1,
    STATE_RTR       = 4'd2,
    STATE_IDE       = 4'd3,
    STATE_R0        = 4'd4,
    STATE_DLC       = 4'd5,
    STATE_DATA      = 4'd6,
    STATE_CRC       = 4'd7,
    STATE_CRC_DELIM = 4'd8,
    STATE_ACK       = 4'd9,
    STATE_ACK_DELIM = 4'd10,
    STATE_EOF       = 4'd11,
    STATE_WAIT_IDLE = 4'd12
  } can_state_e;

  typedef struct packed {
    logic [CAN_ID_BITS-1:0]  id;
    logic                    rtr;
    logic [CAN_DLC_BITS-1:0] dlc;
  } can_frame_t;

  // Number of data bytes actually on the wire: none for remote frames, DLC capped at 8.
  function automatic logic [3:0] can_data_bytes(input logic rtr, input logic [3:0] dlc);
    logic [3:0] n;
    n = (dlc > 4'(CAN_MAX_DATA_BYTES)) ? 4'(CAN_MAX_DATA_BYTES) : dlc;
    if (rtr) begin
      n = 4'd0;
    end
    return n;
  endfunction

endpackage

// File: rtl/can_bit_destuffer.sv
// Bit destuffer: tracks the run of equal bus levels and flags the bit that must be a stuff bit.
module can_bit_destuffer
  import can_defs::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic rx_bit,
  input  logic enable,
  output logic stuff_bit,
  output logic stuff_error
);

  logic       lastBit_q, lastBit_d;
  logic [2:0] run_q, run_d;

  // After STUFF_LEN equal bits the current sample is a stuff bit; equal level there is a violation.
  assign stuff_bit   = enable && (run_q == 3'(STUFF_LEN));
  assign stuff_error = stuff_bit && (rx_bit == lastBit_q);

  // While disabled every sample restarts the run, so the SOF bit seeds a run of one.
  always_comb begin
    lastBit_d = lastBit_q;
    run_d     = run_q;
    if (sample_point) begin
      if (!enable || (rx_bit != lastBit_q)) begin
        lastBit_d = rx_bit;
        run_d     = 3'd1;
      end else begin
        run_d = run_q + 3'd1;
      end
    end
  end

  // Run history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastBit_q <= 1'b1;
      run_q     <= 3'd0;
    end else begin
      lastBit_q <= lastBit_d;
      run_q     <= run_d;
    end
  end

endmodule

// File: rtl/can_receiver.sv
// CAN 2.0A receive engine: destuffs, decodes standard data/remote frames, checks CRC and form.
module can_receiver
  import can_defs::*;
#(
  parameter int STUFF_LEN     = CAN_STUFF_LEN,
  parameter int RECOVERY_BITS = CAN_RECOVERY_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_point,
  input  logic        rx_bit,
  input  logic [14:0] calculated_crc,
  output logic        crc_active,
  output logic [7:0]  rx_data_0,
  output logic [7:0]  rx_data_1,
  output logic [7:0]  rx_data_2,
  output logic [7:0]  rx_data_3,
  output logic [7:0]  rx_data_4,
  output logic [7:0]  rx_data_5,
  output logic [7:0]  rx_data_6,
  output logic [7:0]  rx_data_7,
  output logic [7:0]  rx_data_8,
  output logic [7:0]  rx_data_9,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        ack_tx,
  output logic        crc_error,
  output logic        stuff_error,
  output logic        form_error
);

  localparam int REC_W = $clog2(RECOVERY_BITS + 1);

  can_state_e              state_q, state_d;
  logic [3:0]              bitCnt_q, bitCnt_d;
  logic [3:0]              byteIdx_q, byteIdx_d;
  logic [3:0]              byteCnt_q, byteCnt_d;
  logic [6:0]              shift_q, shift_d;
  can_frame_t              frame_q, frame_d;
  logic [CAN_CRC_BITS-1:0] crcRx_q, crcRx_d;
  logic [REC_W-1:0]        recCnt_q, recCnt_d;
  logic [7:0]              rxData_q [CAN_FRAME_BYTES];
  logic [7:0]              rxData_d [CAN_FRAME_BYTES];
  logic                    rxValid_q, rxValid_d;
  logic                    ackTx_q, ackTx_d;
  logic                    crcErr_q, crcErr_d;
  logic                    stuffErr_q, stuffErr_d;
  logic                    formErr_q, formErr_d;

  logic       destuffEnable;
  logic       stuffBit;
  logic       stuffViolation;
  logic [3:0] dlcFull;
  logic [3:0] nBytes;
  logic [3:0] byteSlot;
  logic [3:0] byteNext;

  can_bit_destuffer #(
    .STUFF_LEN(STUFF_LEN)
  ) u_destuffer (
    .clk          (clk),
    .rst          (rst),
    .sample_point (sample_point),
    .rx_bit       (rx_bit),
    .enable       (destuffEnable),
    .stuff_bit    (stuffBit),
    .stuff_error  (stuffViolation)
  );

  // Stuffing applies from the first ID bit through the last CRC bit; SOF seeds the run while idle.
  always_comb begin
    destuffEnable = 1'b0;
    case (state_q)
      STATE_ID_STD, STATE_RTR, STATE_IDE, STATE_R0,
      STATE_DLC, STATE_DATA, STATE_CRC: destuffEnable = 1'b1;
      default:                          destuffEnable = 1'b0;
    endcase
  end

  // The external CRC unit sees SOF and every non-stuff bit up to the last data bit.
  always_comb begin
    crc_active = 1'b0;
    case (state_q)
      STATE_IDLE:                          crc_active = ~rx_bit;
      STATE_ID_STD, STATE_RTR, STATE_IDE,
      STATE_R0, STATE_DLC, STATE_DATA:     crc_active = ~stuffBit;
      default:                             crc_active = 1'b0;
    endcase
  end

  // Frame decoder: next state, field capture and one-clk status pulses, all on sample_point.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    byteIdx_d  = byteIdx_q;
    byteCnt_d  = byteCnt_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    crcRx_d    = crcRx_q;
    recCnt_d   = recCnt_q;
    rxData_d   = rxData_q;
    ackTx_d    = ackTx_q;
    rxValid_d  = 1'b0;
    crcErr_d   = 1'b0;
    stuffErr_d = 1'b0;
    formErr_d  = 1'b0;
    dlcFull    = {frame_q.dlc[3:1], rx_bit};
    nBytes     = can_data_bytes(frame_q.rtr, dlcFull);
    byteSlot   = byteIdx_q + 4'd2;
    byteNext   = byteIdx_q + 4'd1;

    if (sample_point) begin
      if (stuffViolation) begin
        stuffErr_d = 1'b1;
        state_d    = STATE_WAIT_IDLE;
      end else if (!stuffBit) begin
        case (state_q)
          STATE_IDLE: begin
            if (!rx_bit) begin
              state_d  = STATE_ID_STD;
              bitCnt_d = 4'(CAN_ID_BITS - 1);
              frame_d  = '0;
              for (int i = 2; i < CAN_FRAME_BYTES; i++) begin
                rxData_d[i] = 8'h00;
              end
            end
          end
          STATE_ID_STD: begin
            frame_d.id[bitCnt_q] = rx_bit;
            if (bitCnt_q == 4'd0) begin
              state_d = STATE_RTR;
            end else begin
              bitCnt_d = bitCnt_q - 4'd1;
            end
          end
          STATE_RTR: begin
            frame_d.rtr = rx_bit;
            state_d     = STATE_IDE;
          end
          STATE_IDE: begin
            state_d = rx_bit ? STATE_WAIT_IDLE : STATE_R0;
          end
          STATE_R0: begin
            state_d  = STATE_DLC;
            bitCnt_d = 4'(CAN_DLC_BITS - 1);
          end
          STATE_DLC: begin
            frame_d.dlc[bitCnt_q[1:0]] = rx_bit;
            if (bitCnt_q == 4'd0) begin
              if (nBytes == 4'd0) begin
                state_d  = STATE_CRC;
                bitCnt_d = 4'(CAN_CRC_BITS - 1);
              end else begin
                state_d   = STATE_DATA;
                byteCnt_d = nBytes;
                byteIdx_d = 4'd0;
                bitCnt_d  = 4'd7;
              end
            end else begin
              bitCnt_d = bitCnt_q - 4'd1;
            end
          end
          STATE_DATA: begin
            shift_d = {shift_q[5:0], rx_bit};
            if (bitCnt_q == 4'd0) begin
              rxData_d[byteSlot] = {shift_q, rx_bit};
              byteIdx_d          = byteNext;
              if (byteNext == byteCnt_q) begin
                state_d  = STATE_CRC;
                bitCnt_d = 4'(CAN_CRC_BITS - 1);
              end else begin
                bitCnt_d = 4'd7;
              end
            end else begin
              bitCnt_d = bitCnt_q - 4'd1;
            end
          end
          STATE_CRC: begin
            crcRx_d[bitCnt_q] = rx_bit;
            if (bitCnt_q == 4'd0) begin
              state_d = STATE_CRC_DELIM;
            end else begin
              bitCnt_d = bitCnt_q - 4'd1;
            end
          end
          STATE_CRC_DELIM: begin
            if (!rx_bit) begin
              formErr_d = 1'b1;
              state_d   = STATE_WAIT_IDLE;
            end else if (crcRx_q != calculated_crc) begin
              crcErr_d = 1'b1;
              state_d  = STATE_WAIT_IDLE;
            end else begin
              ackTx_d = 1'b1;
              state_d = STATE_ACK;
            end
          end
          STATE_ACK: begin
            ackTx_d = 1'b0;
            state_d = STATE_ACK_DELIM;
          end
          STATE_ACK_DELIM: begin
            if (!rx_bit) begin
              formErr_d = 1'b1;
              state_d   = STATE_WAIT_IDLE;
            end else begin
              state_d  = STATE_EOF;
              bitCnt_d = 4'(CAN_EOF_BITS - 1);
            end
          end
          STATE_EOF: begin
            if (!rx_bit) begin
              formErr_d = 1'b1;
              state_d   = STATE_WAIT_IDLE;
            end else if (bitCnt_q == 4'd0) begin
              rxValid_d   = 1'b1;
              rxData_d[0] = frame_q.id[10:3];
              rxData_d[1] = {frame_q.id[2:0], frame_q.rtr, frame_q.dlc};
              state_d     = STATE_IDLE;
            end else begin
              bitCnt_d = bitCnt_q - 4'd1;
            end
          end
          STATE_WAIT_IDLE: begin
            if (!rx_bit) begin
              recCnt_d = '0;
            end else if (recCnt_q == REC_W'(RECOVERY_BITS - 1)) begin
              recCnt_d = '0;
              state_d  = STATE_IDLE;
            end else begin
              recCnt_d = recCnt_q + 1'b1;
            end
          end
          default: begin
            state_d = STATE_IDLE;
          end
        endcase
      end
    end
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= STATE_IDLE;
      bitCnt_q   <= 4'd0;
      byteIdx_q  <= 4'd0;
      byteCnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      frame_q    <= '0;
      crcRx_q    <= '0;
      recCnt_q   <= '0;
      rxData_q   <= '{default: 8'h00};
      rxValid_q  <= 1'b0;
      ackTx_q    <= 1'b0;
      crcErr_q   <= 1'b0;
      stuffErr_q <= 1'b0;
      formErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      byteIdx_q  <= byteIdx_d;
      byteCnt_q  <= byteCnt_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
      crcRx_q    <= crcRx_d;
      recCnt_q   <= recCnt_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      ackTx_q    <= ackTx_d;
      crcErr_q   <= crcErr_d;
      stuffErr_q <= stuffErr_d;
      formErr_q  <= formErr_d;
    end
  end

  assign rx_data_0   = rxData_q[0];
  assign rx_data_1   = rxData_q[1];
  assign rx_data_2   = rxData_q[2];
  assign rx_data_3   = rxData_q[3];
  assign rx_data_4   = rxData_q[4];
  assign rx_data_5   = rxData_q[5];
  assign rx_data_6   = rxData_q[6];
  assign rx_data_7   = rxData_q[7];
  assign rx_data_8   = rxData_q[8];
  assign rx_data_9   = rxData_q[9];
  assign rx_valid    = rxValid_q;
  assign rx_busy     = (state_q != STATE_IDLE);
  assign ack_tx      = ackTx_q;
  assign crc_error   = crcErr_q;
  assign stuff_error = stuffErr_q;
  assign form_error  = formErr_q;

endmodule

// File: doc/can_receiver.md
Name: can_receiver

Overview:
- Bit-level receive engine for classical CAN standard (11-bit ID) data and remote frames.
- Samples the bus at each `sample_point` from the bit-timing unit and removes stuff bits.
- Gates the external CRC-15 unit via `crc_active`, compares the received CRC against `calculated_crc`, and requests a dominant ACK on a good frame.
- Presents the frame in the same 10-byte layout the transmitter consumes (byte 0 = ID[10:3]; byte 1 = {ID[2:0], RTR, DLC}; bytes 2..9 = data), and flags stuff, CRC and form errors.

Parameters:
- STUFF_LEN, 5, number of equal consecutive bits after which a stuff bit is expected.
- RECOVERY_BITS, 11, consecutive recessive bits required to leave WAIT_IDLE.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sample_point  in  1  one-clk strobe; all bit-level updates occur only when high
- rx_bit  in  1  synchronised bus level (0 = dominant)
- calculated_crc  in  15  running CRC from the external CRC unit
- crc_active  out  1  CRC unit shifts `rx_bit` on this sample_point (non-stuff bits, SOF through last data bit)
- rx_data_0..rx_data_9  out  8 each  received frame bytes, layout as above
- rx_valid  out  1  one-clk pulse: frame complete and error-free
- rx_busy  out  1  high from SOF until return to IDLE
- ack_tx  out  1  request to drive dominant in the ACK slot
- crc_error / stuff_error / form_error  out  1 each  one-clk error pulses

Behaviour:
- Reset:
  - All outputs 0; `rx_data_*` = 0x00.
  - State IDLE; counters and history cleared. Reset mid-frame abandons the frame with no pulses.
- Registered outputs: all outputs except `crc_active` are registered and update in the clk cycle after the qualifying sample_point. `crc_active` is combinational from state and stuff status.
- Destuffing (active from SOF through the last CRC bit):
  - Track the last bit and a run counter (3 bits).
  - After STUFF_LEN equal bits, the next sample is a stuff bit: discard it (no state advance, `crc_active` = 0) and reset the run to 1 with the new level.
  - If the stuff bit equals the previous level: pulse `stuff_error` and go to WAIT_IDLE.
- States: IDLE, ID_STD(11), RTR, IDE, R0, DLC(4), DATA, CRC(15), CRC_DELIM, ACK, ACK_DELIM, EOF(7), WAIT_IDLE.
- IDLE: a dominant sample is SOF. Go to ID_STD, bit counter = 10, clear the data byte buffer, `crc_active` = 1.
- ID_STD: shift MSB first into ID[counter]. At 0 go to RTR.
- RTR: latch the bit, then go to IDE.
- IDE: dominant → R0. Recessive → extended frame, unsupported: go to WAIT_IDLE silently (no error pulse).
- R0: go to DLC, counter = 3.
- DLC: capture MSB first. At bit 0:
  - if RTR = 1 or DLC = 0 → CRC, counter = 14;
  - else → DATA, byte count = min(DLC, 8).
- DATA:
  - Shift MSB first into a shift register.
  - On every 8th bit, write the byte to `rx_data_{2+idx}`.
  - After the last byte → CRC, counter = 14.
- CRC:
  - Capture 15 bits MSB first, `crc_active` = 0.
  - `calculated_crc` is frozen from the last data bit on.
- CRC_DELIM:
  - Dominant → `form_error`, WAIT_IDLE.
  - Else if the received CRC ≠ `calculated_crc` → `crc_error`, WAIT_IDLE.
  - Else set `ack_tx` = 1 and go to ACK.
- ACK: clear `ack_tx`, go to ACK_DELIM. The ACK-slot level is ignored.
- ACK_DELIM: dominant → `form_error`, WAIT_IDLE; else → EOF, counter = 6.
- EOF:
  - Any dominant → `form_error`, WAIT_IDLE.
  - At counter 0 (recessive): pulse `rx_valid`, latch ID/RTR/DLC into `rx_data_0`/`rx_data_1`, go to IDLE.
- WAIT_IDLE: count consecutive recessive samples; a dominant sample restarts the count. At RECOVERY_BITS → IDLE.
- Frame bytes:
  - `rx_data_0`/`rx_data_1` update only on `rx_valid`.
  - `rx_data_2..9` update progressively and are stable after `rx_valid`.
  - Bytes beyond DLC hold 0x00.
  - DLC > 8: receive 8 bytes, report the raw DLC.
- `rx_busy` = 1 in all states except IDLE.

Decomposition:
- can_defs package:
  - add `STATE_WAIT_IDLE` to the shared frame-state enum;
  - add `CAN_STUFF_LEN`, `CAN_EOF_BITS`, `CAN_CRC_BITS` constants;
  - reuse the `can_frame_t` struct for captured fields.
- One sub-module, `can_bit_destuffer`: inputs `sample_point`, `rx_bit`, `enable`; outputs `stuff_bit` (discard) and `stuff_error`.

Test Plan:
- Data frame, ID 0x123, DLC 2, data A5 5A, correct CRC, with stuff bits inserted → `rx_data_0` = 0x24, `rx_data_1` = 0x62, `rx_data_2` = 0xA5, `rx_data_3` = 0x5A, `rx_data_4..9` = 0x00, `ack_tx` high for exactly one bit, one `rx_valid` pulse.
- Remote frame, ID 0x7FF, RTR = 1, DLC 4 → no DATA state, `rx_data_1` = 0xF4, `rx_valid` pulse, `crc_active` low from the first CRC bit.
- Six dominant bits in the ID field → `stuff_error` pulse at the 6th bit; no `rx_valid`; exits WAIT_IDLE after 11 recessive bits; a following good frame is received.
- CRC field with one bit flipped → `crc_error` pulse at CRC_DELIM, `ack_tx` never asserted.
- Dominant bit at EOF position 4 → `form_error` pulse, no `rx_valid`.
- `rst` asserted mid-DATA, then a fresh frame → all outputs 0 during reset, and the next frame is decoded correctly.
